// File: rtl/prng_index_sampler.sv
`default_nettype none
// ============================================================================
// Module  : prng_index_sampler
// Purpose : Slices prng words into W-bit chunks and rejection-samples them
//           into uniform indices in [0, N), one per valid/ack handshake.
// Revision: 1.0
// ============================================================================
module prng_index_sampler #(
    parameter int N      = 189,
    parameter int W      = 8,
    parameter int RNG_W  = 96,
    parameter int CNT_W  = 8,
    parameter int CHUNKS = RNG_W / W
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_ready,
    input  logic [CNT_W-1:0] in_count,
    input  logic             in_ack,
    output logic             rng_req,
    output logic             rng_mod,
    input  logic [RNG_W-1:0] rng_data,
    input  logic             rng_done,
    output logic [W-1:0]     out_idx,
    output logic             out_valid,
    output logic             out_busy,
    output logic             out_done,
    output logic [15:0]      out_rejects
);

    localparam int PTR_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_SLICE = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q;
    logic [W-1:0]       buf_q [CHUNKS];
    logic [PTR_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [W-1:0]       idx_q;
    logic               valid_q;
    logic               done_q;
    logic [15:0]        rejects_q;

    logic [W-1:0]       w_chunk;
    logic               w_accept;
    logic               w_last;

    assign w_chunk  = buf_q[ptr_q];
    // Widened compare so that N == 2^W accepts every chunk.
    assign w_accept = ({1'b0, w_chunk} < (W+1)'(N));
    assign w_last   = (ptr_q == PTR_W'(CHUNKS - 1));

    assign rng_req     = (state_q == S_REQ) && !rng_done;
    assign rng_mod     = 1'b0;
    assign out_busy    = (state_q != S_IDLE);
    assign out_idx     = idx_q;
    assign out_valid   = valid_q;
    assign out_done    = done_q;
    assign out_rejects = rejects_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            for (int c = 0; c < CHUNKS; c++) buf_q[c] <= '0;
            ptr_q       <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            rejects_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_ready) begin
                        remaining_q <= in_count;
                        rejects_q   <= '0;
                        state_q     <= (in_count == '0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    // A still-high done belongs to the previous word; wait it out.
                    if (!rng_done) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (rng_done) begin
                        for (int c = 0; c < CHUNKS; c++) buf_q[c] <= rng_data[c*W +: W];
                        ptr_q   <= '0;
                        state_q <= S_SLICE;
                    end
                end
                S_SLICE: begin
                    if (w_accept) begin
                        idx_q   <= w_chunk;
                        valid_q <= 1'b1;
                        state_q <= S_EMIT;
                    end else begin
                        if (rejects_q != 16'hFFFF) rejects_q <= rejects_q + 16'd1;
                        if (w_last) state_q <= S_REQ;
                        else        ptr_q   <= ptr_q + PTR_W'(1);
                    end
                end
                S_EMIT: begin
                    if (in_ack) begin
                        valid_q     <= 1'b0;
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= S_DONE;
                        end else if (w_last) begin
                            state_q <= S_REQ;
                        end else begin
                            ptr_q   <= ptr_q + PTR_W'(1);
                            state_q <= S_SLICE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/prng_index_sampler.md
Name: prng_index_sampler

Overview:
- Consumer stage directly downstream of prng.
- Requests 96-bit words from prng and slices each into W-bit chunks.
- Rejection-samples the chunks to give uniform indices in [0, N) for support/position generation.
- Delivers indices one at a time over a valid/ack handshake until a requested count is reached, then pulses done.

Parameters:
- N, 189, exclusive upper bound of emitted indices; must satisfy 1 <= N <= 2^W.
- W, 8, chunk width in bits; ceil(log2(N)).
- RNG_W, 96, prng output width.
- CNT_W, 8, width of the request count.
- CHUNKS, RNG_W/W (=12), derived; chunks used per word, LSB chunk first; the RNG_W mod W leftover bits are discarded.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_b  in  1  asynchronous active-low reset.
- in_ready  in  1  start pulse; sampled only in IDLE.
- in_count  in  CNT_W  number of indices to produce; latched with in_ready.
- in_ack  in  1  downstream accepts out_idx while out_valid=1.
- rng_req  out  1  one-cycle pulse to prng in_ready.
- rng_mod  out  1  tied 0; the sampler never reseeds.
- rng_data  in  RNG_W  prng out_rng.
- rng_done  in  1  prng out_ready; level, high while rng_data is valid.
- out_idx  out  W  sampled index, always < N when out_valid=1.
- out_valid  out  1  out_idx valid; held until in_ack.
- out_busy  out  1  high in every state except IDLE.
- out_done  out  1  one-cycle pulse after the last index is accepted.
- out_rejects  out  16  saturating count of rejected chunks since the last start.

Behaviour:
Reset (rst_b=0, async):
- State goes to IDLE.
- Outputs return to: rng_req=0, out_valid=0, out_idx=0, out_busy=0, out_done=0, out_rejects=0.
- Word buffer, chunk pointer and remaining counter clear.
- Reset mid-operation abandons any outstanding prng request; late rng_done is ignored until the next REQ.

FSM states:
- IDLE: on in_ready=1, latch in_count into remaining and clear out_rejects.
  - remaining==0 -> DONE.
  - Otherwise -> REQ.
  - in_ready in any other state is ignored.
- REQ: if rng_done=1, stay in REQ; a new word is never requested until the previous done has dropped. Otherwise assert rng_req for exactly this cycle -> WAIT.
- WAIT: on rng_done=1, capture rng_data into the buffer, set ptr=0 -> SLICE.
- SLICE: chunk = buf[ptr*W +: W].
  - chunk < N: register out_idx=chunk, set out_valid=1 -> EMIT.
  - chunk >= N: increment out_rejects (saturating at 16'hFFFF).
  - On reject with ptr==CHUNKS-1 -> REQ; otherwise ptr++ and stay in SLICE.
  - Costs one cycle per chunk.
- EMIT: hold out_valid and out_idx stable until in_ack=1. In the ack cycle: out_valid->0 and remaining--.
  - remaining becomes 0 -> DONE.
  - Else if ptr==CHUNKS-1 -> REQ.
  - Else ptr++ -> SLICE.
- DONE: out_done=1 for one cycle -> IDLE.

Timing and boundaries:
- Latency from in_ready (cycle 0) to rng_req: rng_req is high in cycle 1, out_busy high from cycle 1.
- Fastest index: emitted 1 cycle after capture, when chunk 0 is accepted.
- Indices are not deduplicated. Duplicates are legal at this stage; the consumer filters them.
- in_ack while out_valid=0 is ignored.
- Only bits [CHUNKS*W-1:0] of rng_data are used.
- N == 2^W: no rejections occur.

Test Plan:
- Reset check: assert rst_b=0 mid-WAIT -> all outputs 0 immediately; after release, rng_done=1 has no effect and out_valid stays 0 until a new start.
- Basic sampling: N=189, W=8, in_count=3, word low bytes 0x00,0xBC,0xBD,0xFF,0x05, in_ack always 1 -> out_idx sequence 0x00, 0xBC, 0x05; out_rejects=2; one out_done pulse; exactly one rng_req.
- Word exhaustion: in_count=2, first word all 0xFF, second word 0x07 in chunk 0 and 0x10 in chunk 1 -> 12 rejects, second rng_req issued only after rng_done low; emits 0x07, 0x10.
- Backpressure: in_ack held 0 for 5 cycles -> out_idx/out_valid stable for 5 cycles; advance on the first ack cycle; remaining decremented exactly once.
- Zero count: in_count=0 -> out_done pulse in cycle 2, no rng_req, out_valid never 1.
- Ignored start: in_ready pulsed during EMIT -> no change to remaining, no extra rng_req; rng_mod is 0 throughout.
